// File: rtl/data_mem.sv
// data_mem: little-endian byte-addressed data memory with load/store fault detection.
// Optional store trace enabled by defining DM_DISPLAY_EN.
module data_mem #(
    parameter int WORD_ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [1:0]  store_type,
    input  logic        re,
    input  logic [2:0]  load_type,
    output logic [31:0] rdata,
    output logic        addr_err
);
    localparam int DEPTH = 1 << WORD_ADDR_W;
    logic [31:0] mem [DEPTH];
    logic [WORD_ADDR_W-1:0] idx;
    logic [31:0] word, merged, wsrc;
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [3:0]  be;
    logic        range_err, st_err, ld_err, commit;
    logic        unused_pc;
    assign unused_pc = ^pc;
    assign idx  = addr[WORD_ADDR_W+1:2];
    assign word = mem[idx];
    // Fault detection: each enabled access is checked against its own type.
    always_comb begin
        range_err = (addr >> (WORD_ADDR_W + 2)) != 32'd0;
        st_err = we & (range_err | (store_type == 2'b11)
                 | ((store_type == 2'b00) & (addr[1:0] != 2'b00))
                 | ((store_type == 2'b01) & addr[0]));
        ld_err = re & (range_err | (load_type > 3'b100)
                 | ((load_type == 3'b000) & (addr[1:0] != 2'b00))
                 | (((load_type == 3'b001) | (load_type == 3'b010)) & addr[0]));
        addr_err = st_err | ld_err;
        commit = we & ~addr_err;
    end
    // Store merge: replicate the store data across lanes and pick lanes by byte enable.
    always_comb begin
        be = store_type == 2'b00 ? 4'hF :
             store_type == 2'b01 ? (addr[1] ? 4'hC : 4'h3) :
             4'b0001 << addr[1:0];
        wsrc = store_type == 2'b00 ? wdata :
               store_type == 2'b01 ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        merged = word;
        for (int i = 0; i < 4; i++)
            if (be[i]) merged[8*i +: 8] = wsrc[8*i +: 8];
    end
    // Load extract and extension; zero whenever the load is disabled or any fault is flagged.
    always_comb begin
        half = addr[1] ? word[31:16] : word[15:0];
        byte_v = word[8*addr[1:0] +: 8];
        rdata = ~re | addr_err ? 32'd0 :
                load_type == 3'b000 ? word :
                load_type == 3'b001 ? {{16{half[15]}}, half} :
                load_type == 3'b010 ? {16'd0, half} :
                load_type == 3'b011 ? {{24{byte_v[7]}}, byte_v} :
                load_type == 3'b100 ? {24'd0, byte_v} : 32'd0;
    end
    // Memory update: reset clears every word and overrides any store in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else if (commit) begin
            mem[idx] <= merged;
`ifdef DM_DISPLAY_EN
            $display("@%08h: *%08h <= %08h", pc, {addr[31:2], 2'b00}, merged);
`endif
        end
    end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed self-checking bench for data_mem.
module tb_data_mem;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        we = 1'b0;
    logic [1:0]  store_type = 2'b00;
    logic        re = 1'b0;
    logic [2:0]  load_type = 3'b000;
    logic [31:0] rdata;
    logic        addr_err;
    int total = 0;
    int bad = 0;

    data_mem #(.WORD_ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .pc(pc), .addr(addr), .wdata(wdata),
        .we(we), .store_type(store_type), .re(re), .load_type(load_type),
        .rdata(rdata), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        re = 1'b0; we = 1'b1; addr = a; wdata = d; store_type = t;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] t);
        we = 1'b0; re = 1'b1; addr = a; load_type = t;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'hFFC};
        for (int i = 0; i < 3; i++) begin
            do_load(addrs[i], 3'b000);
            total++;
            if (rdata !== 32'd0) begin bad++; $display("FAIL reset_lw addr=%h got=%h exp=00000000", addrs[i], rdata); end
            total++;
            if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_err addr=%h got=%b exp=0", addrs[i], addr_err); end
        end
        re = 1'b0;
    endtask

    task automatic test_word_byte();
        logic [31:0] a [4] = '{32'h10, 32'h10, 32'h13, 32'h12};
        logic [2:0]  t [4] = '{3'b000, 3'b011, 3'b011, 3'b010};
        logic [31:0] e [4] = '{32'h12345678, 32'h00000078, 32'h00000012, 32'h00001234};
        do_store(32'h10, 32'h12345678, 2'b00);
        for (int i = 0; i < 4; i++) begin
            do_load(a[i], t[i]);
            total++;
            if (rdata !== e[i] || addr_err !== 1'b0) begin bad++; $display("FAIL word_byte addr=%h type=%0d got=%h/%b exp=%h/0", a[i], t[i], rdata, addr_err, e[i]); end
        end
        re = 1'b0;
    endtask

    task automatic test_merge();
        logic [31:0] a [5] = '{32'h20, 32'h22, 32'h21, 32'h21, 32'h20};
        logic [2:0]  t [5] = '{3'b000, 3'b001, 3'b100, 3'b011, 3'b010};
        logic [31:0] e [5] = '{32'h80FFAB00, 32'hFFFF80FF, 32'h000000AB, 32'hFFFFFFAB, 32'h0000AB00};
        do_store(32'h20, 32'h0, 2'b00);
        do_store(32'h21, 32'h777777AB, 2'b10);
        do_store(32'h22, 32'h555580FF, 2'b01);
        for (int i = 0; i < 5; i++) begin
            do_load(a[i], t[i]);
            total++;
            if (rdata !== e[i] || addr_err !== 1'b0) begin bad++; $display("FAIL merge addr=%h type=%0d got=%h/%b exp=%h/0", a[i], t[i], rdata, addr_err, e[i]); end
        end
        re = 1'b0;
    endtask

    task automatic test_faults();
        we = 1'b1; re = 1'b0; addr = 32'h25; wdata = 32'hDEADBEEF; store_type = 2'b00;
        #1 total++;
        if (addr_err !== 1'b1) begin bad++; $display("FAIL sw_misalign_err got=%b exp=1", addr_err); end
        @(posedge clk); #1 we = 1'b0;
        do_load(32'h24, 3'b000);
        total++;
        if (rdata !== 32'd0) begin bad++; $display("FAIL sw_misalign_nowrite got=%h exp=00000000", rdata); end
        re = 1'b0; we = 1'b1; addr = 32'h23; store_type = 2'b01;
        #1 total++;
        if (addr_err !== 1'b1) begin bad++; $display("FAIL sh_misalign_err got=%b exp=1", addr_err); end
        we = 1'b0;
        do_load(32'h1000, 3'b000);
        total++;
        if (addr_err !== 1'b1 || rdata !== 32'd0) begin bad++; $display("FAIL range got=%h/%b exp=00000000/1", rdata, addr_err); end
        do_load(32'h8000_0010, 3'b100);
        total++;
        if (addr_err !== 1'b1 || rdata !== 32'd0) begin bad++; $display("FAIL range_high got=%h/%b exp=00000000/1", rdata, addr_err); end
        do_load(32'h23, 3'b011);
        total++;
        if (addr_err !== 1'b0 || rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_odd got=%h/%b exp=ffffff80/0", rdata, addr_err); end
        do_load(32'h20, 3'b101);
        total++;
        if (addr_err !== 1'b1 || rdata !== 32'd0) begin bad++; $display("FAIL load_type got=%h/%b exp=00000000/1", rdata, addr_err); end
        do_load(32'h22, 3'b010);
        total++;
        if (addr_err !== 1'b0 || rdata !== 32'h000080FF) begin bad++; $display("FAIL lhu_hi got=%h/%b exp=000080ff/0", rdata, addr_err); end
        re = 1'b0; we = 1'b1; addr = 32'h28; wdata = 32'hFFFFFFFF; store_type = 2'b11;
        #1 total++;
        if (addr_err !== 1'b1) begin bad++; $display("FAIL store_type_err got=%b exp=1", addr_err); end
        @(posedge clk); #1 we = 1'b0;
        do_load(32'h28, 3'b000);
        total++;
        if (rdata !== 32'd0) begin bad++; $display("FAIL store_type_nowrite got=%h exp=00000000", rdata); end
        re = 1'b0; addr = 32'h1001; load_type = 3'b000; store_type = 2'b00;
        #1 total++;
        if (addr_err !== 1'b0 || rdata !== 32'd0) begin bad++; $display("FAIL idle got=%h/%b exp=00000000/0", rdata, addr_err); end
    endtask

    task automatic test_back_to_back();
        do_store(32'h30, 32'h11111111, 2'b00);
        we = 1'b1; re = 1'b1; addr = 32'h30; wdata = 32'h22222222; store_type = 2'b00; load_type = 3'b000;
        #1 total++;
        if (rdata !== 32'h11111111 || addr_err !== 1'b0) begin bad++; $display("FAIL same_cycle_old got=%h/%b exp=11111111/0", rdata, addr_err); end
        @(posedge clk); #1 we = 1'b0;
        total++;
        if (rdata !== 32'h22222222) begin bad++; $display("FAIL same_cycle_new got=%h exp=22222222", rdata); end
        re = 1'b0;
    endtask

    task automatic test_reset_priority();
        pc = 32'h3000;
        do_store(32'h44, 32'h5, 2'b00);
        do_load(32'h44, 3'b000);
        total++;
        if (rdata !== 32'h5) begin bad++; $display("FAIL trace_store got=%h exp=00000005", rdata); end
        re = 1'b0; reset = 1'b1;
        do_store(32'h40, 32'h5, 2'b00);
        reset = 1'b0;
        do_load(32'h40, 3'b000);
        total++;
        if (rdata !== 32'd0) begin bad++; $display("FAIL reset_vs_we got=%h exp=00000000", rdata); end
        do_load(32'h10, 3'b000);
        total++;
        if (rdata !== 32'd0) begin bad++; $display("FAIL reset_clears got=%h exp=00000000", rdata); end
        re = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_word_byte();
        test_merge();
        test_faults();
        test_back_to_back();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Data memory stage directly downstream of the ALU in the single-cycle MIPS datapath.
- Takes ALUout as the byte address for lw/lh/lhu/lb/lbu/sw/sh/sb.
- Performs little-endian byte/half/word merges on store and sign/zero extension on load.
- Flags misaligned or out-of-range accesses; feeds the register-file write-back mux.

Parameters:
- WORD_ADDR_W, 10, log2 of word count (1024 words = 4 KiB, byte range 0x0000_0000..0x0000_0FFF)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears every memory word
- pc  input  32  PC of the instruction in this cycle; used only for the write trace
- addr  input  32  byte address (ALUout)
- wdata  input  32  store data (rt value)
- we  input  1  store enable
- store_type  input  2  00 sw, 01 sh, 10 sb, 11 invalid
- re  input  1  load enable
- load_type  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101-111 invalid
- rdata  output  32  extended load result (combinational)
- addr_err  output  1  access fault for the current cycle (combinational)

Behaviour:
- Storage: 2^WORD_ADDR_W x 32 array. Word index = addr[WORD_ADDR_W+1:2]. Byte lane = addr[1:0]; lane 0 = bits 7:0 (little-endian).
- Reset:
  - On a rising clk edge with reset=1, every word becomes 0. No write occurs in that cycle.
  - reset has priority over we.
  - Reset asserted mid-sequence discards that cycle's store.
- Fault detection (combinational):
  - range_err: addr >= 4*2^WORD_ADDR_W.
  - align_err: sw or lw with addr[1:0]!=0; sh, lh or lhu with addr[0]!=0. Byte accesses never misalign.
  - type_err: we with store_type=11, or re with load_type>=101.
  - addr_err = (we|re) & (range_err|align_err|type_err). It is 0 whenever we=re=0.
- Store (rising edge, reset=0, we=1, no fault):
  - sw: word <= wdata.
  - sh: halfword at addr[1] <= wdata[15:0]; the other half is unchanged.
  - sb: byte at addr[1:0] <= wdata[7:0]; the other three bytes are unchanged.
  - A faulting store writes nothing.
- Load (combinational):
  - When re=1 with no fault, the word is read and the selected field extracted.
  - lh and lb sign-extend; lhu and lbu zero-extend; lw passes the word through.
  - rdata = 0 when re=0 or addr_err=1.
- Timing:
  - Read latency 0 cycles. Write latency 1 edge.
  - Load and store to the same address in the same cycle: rdata shows the pre-write value. The new value is visible after the edge.
- we and re both 1: legal. Each is checked against its own type. addr_err is the OR of both checks.
- Address bits above WORD_ADDR_W+1 only participate in range_err and never alias.
- Outputs carry no reset value of their own; they are combinational. After any reset edge every in-range aligned load returns 0.

Optional Feature:
- Macro: DM_DISPLAY_EN
- Defined: each committed store prints at the rising edge, in the form "@<pc 8-hex>: *<word-aligned addr 8-hex> <= <full merged word 8-hex>".
  - Printed word is the post-merge value.
  - Faulting stores and reset cycles print nothing.
- Undefined: no simulation output; synthesised logic is identical either way.

Test Plan:
- Reset then lw 0x0, 0x4, 0xFFC -> rdata=0x00000000 each, addr_err=0.
- sw 0x12345678 to 0x10; lw 0x10 -> 0x12345678; lb 0x10 -> 0x00000078; lb 0x13 -> 0x00000012; lhu 0x12 -> 0x00001234.
- sw 0x0 to 0x20; sb 0xAB to 0x21; sh 0x80FF to 0x22; lw 0x20 -> 0x80FFAB00; lh 0x22 -> 0xFFFF80FF; lbu 0x21 -> 0x000000AB; lb 0x21 -> 0xFFFFFFAB.
- Faults:
  - sw 0xDEADBEEF to 0x25 -> addr_err=1, word 0x24 unchanged.
  - sh to 0x23 -> addr_err=1.
  - lw 0x1000 -> addr_err=1, rdata=0.
  - we=1 with store_type=11 -> addr_err=1, no write.
- Same-cycle read/write: 0x30 holds 0x11111111; sw 0x22222222 to 0x30 with lw 0x30 in the same cycle -> rdata=0x11111111 that cycle, 0x22222222 the next.
- reset=1 and we=1 (sw 0x5 to 0x40) on the same edge -> lw 0x40 returns 0. With DM_DISPLAY_EN, sw 0x5 to 0x44 at pc=0x3000 prints "@00003000: *00000044 <= 00000005".
